conv_maxpool2x2: RTL and testbench

- Streaming 2x2 max-pool stage directly downstream of muladdtree3x3.
- Consumes one signed 21-bit convolved_result per valid cycle in raster order over an IMG_W x IMG_H conv feature map.
- Emits one pooled value per 2x2 window, in raster order of the pooled map (IMG_W/2 x IMG_H/2).
- Keeps a half-row buffer of horizontal-pair maxima so each pixel is read exactly once; no backpressure.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/pool_row_buffer.sv | 25 ++
 rtl/conv_maxpool2x2.sv | 110 +++++++++++
 tb/tb_conv_maxpool2x2.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath width and signed helpers (max2, relu).
// CONV_W is the convolved_result width used by muladdtree3x3 and pooling.
package cnn_pkg;

  localparam int CONV_W = 21;

  typedef logic signed [CONV_W-1:0] conv_t;

  function automatic conv_t max2(
    input conv_t a,
    input conv_t b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic conv_t relu(input conv_t x);
    return x[CONV_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: DEPTH x CONV_W single-port row memory, sync write,
// async read at addr. Ports: clk, we, addr, wdata, rdata. No reset.
module pool_row_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  conv_t         wdata,
  output conv_t         rdata
);

  conv_t mem [DEPTH];

  // contents are always written on an even row before being read
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// conv_maxpool2x2: streaming 2x2 max-pool over an IMG_W x IMG_H raster.
// Ports: clk, reset (async low), frame_start, conv_valid/conv_data in;
// pool_valid/pool_data/frame_done out. Macro CONV_MAXPOOL_RELU_EN: ReLU.
module conv_maxpool2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = CONV_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              conv_valid,
  input  logic [DATA_W-1:0] conv_data,
  output logic              pool_valid,
  output logic [DATA_W-1:0] pool_data,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HD = IMG_W / 2;
  localparam int AW = (HD > 1) ? $clog2(HD) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] row;
  logic [RW-1:0] cur_row;
  logic [AW-1:0] buf_addr;
  logic          buf_we;
  logic          odd_col;
  logic          odd_row;
  logic          last_col;
  logic          last_row;

  conv_t hmax;
  conv_t fx;
  conv_t pair;
  conv_t above;
  conv_t win;

  // frame_start makes this cycle's sample pixel (0,0)
  always_comb begin
    cur_col = frame_start ? '0 : col;
    cur_row = frame_start ? '0 : row;
`ifdef CONV_MAXPOOL_RELU_EN
    fx = relu(conv_t'(conv_data));
`else
    fx = conv_t'(conv_data);
`endif
    pair     = max2(hmax, fx);
    win      = max2(above, pair);
    odd_col  = cur_col[0];
    odd_row  = cur_row[0];
    last_col = (cur_col == COL_LAST);
    last_row = (cur_row == ROW_LAST);
    buf_addr = AW'(cur_col >> 1);
    buf_we   = conv_valid & odd_col & ~odd_row;
  end

  pool_row_buffer #(
    .DEPTH (HD),
    .AW    (AW)
  ) u_rowbuf (
    .clk   (clk),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (pair),
    .rdata (above)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col        <= '0;
      row        <= '0;
      hmax       <= '0;
      pool_valid <= 1'b0;
      pool_data  <= '0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start) begin
        col  <= '0;
        row  <= '0;
        hmax <= '0;
      end
      if (conv_valid) begin
        if (!odd_col) begin
          hmax <= fx;
        end else if (odd_row) begin
          pool_data  <= DATA_W'(win);
          pool_valid <= 1'b1;
          frame_done <= last_col & last_row;
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// tb_conv_maxpool2x2: directed bench for conv_maxpool2x2 at 4x4 with a
// window-level reference model and a per-cycle output scoreboard.
module tb_conv_maxpool2x2;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          conv_valid = 1'b0;
  logic [DW-1:0] conv_data = '0;
  logic          pool_valid;
  logic [DW-1:0] pool_data;
  logic          frame_done;

  conv_maxpool2x2 #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .conv_valid  (conv_valid),
    .conv_data   (conv_data),
    .pool_valid  (pool_valid),
    .pool_data   (pool_data),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
    bit fd;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            n = 0;
  int            fd_cnt = 0;
  int            img [H][W];
  exp_t          q[$];
  logic [DW-1:0] seen[$];

  always @(posedge clk) cyc++;

  function automatic int f(input int v);
`ifdef CONV_MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // drive one pixel; model records it at its frame position
  task automatic px(input int v, input bit fs);
    int r;
    int c;
    exp_t e;
    @(posedge clk);
    #1;
    conv_valid  = 1'b1;
    frame_start = fs;
    conv_data   = v[DW-1:0];
    if (fs) n = 0;
    r = n / W;
    c = n % W;
    img[r][c] = f(v);
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.cyc = cyc + 1;
      e.val = mx(mx(img[r-1][c-1], img[r-1][c]),
                 mx(img[r][c-1], img[r][c]));
      e.fd  = (n == W * H - 1);
      q.push_back(e);
    end
    n = (n + 1) % (W * H);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      conv_valid  = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic ramp(input int gap);
    for (int i = 0; i < W * H; i++) begin
      px(i, 1'b0);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic chk(input string nm, input int got, input int req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic chk_seen(input string nm, input logic [DW-1:0] e[$],
                          input int fds);
    chk({nm, "_count"}, seen.size(), e.size());
    for (int i = 0; i < e.size() && i < seen.size(); i++)
      chk($sformatf("%s_out%0d", nm, i), int'(seen[i]), int'(e[i]));
    chk({nm, "_frame_done"}, fd_cnt, fds);
    seen.delete();
    fd_cnt = 0;
  endtask

  // scoreboard: every cycle with an expected or actual pulse
  always @(negedge clk) begin
    if (reset) begin
      bit due;
      due = (q.size() > 0) && (q[0].cyc == cyc);
      if (pool_valid || due) begin
        tests++;
        if (pool_valid !== due) begin
          fails++;
          $display("FAIL sb_valid cyc %0d: got %0b required %0b",
                   cyc, pool_valid, due);
        end else if (int'($signed(pool_data)) != q[0].val ||
                     frame_done !== q[0].fd) begin
          fails++;
          $display("FAIL sb_data cyc %0d: got %0d/%0b required %0d/%0b",
                   cyc, $signed(pool_data), frame_done,
                   q[0].val, q[0].fd);
        end
        if (due) void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL sb_missed cyc %0d: got none required pulse", cyc);
        void'(q.pop_front());
      end
      if (frame_done && !pool_valid) begin
        tests++;
        fails++;
        $display("FAIL sb_fd_alone cyc %0d: got 1 required 0", cyc);
      end
      if (pool_valid) seen.push_back(pool_data);
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    logic [DW-1:0] e[$];
    logic [DW-1:0] neg;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(pool_valid), 0);
    chk("rst_data", int'(pool_data), 0);
    chk("rst_fd", int'(frame_done), 0);
    reset = 1'b1;

    // ramp, valid every cycle
    ramp(0);
    idle(3);
    e = '{21'd5, 21'd7, 21'd13, 21'd15};
    chk_seen("ramp", e, 1);

    // ramp, valid every 3rd cycle
    ramp(2);
    idle(3);
    chk_seen("gapped", e, 1);

    // all -3
    for (int i = 0; i < W * H; i++) px(-3, 1'b0);
    idle(3);
`ifdef CONV_MAXPOOL_RELU_EN
    neg = 21'd0;
`else
    neg = 21'h1FFFFD;
`endif
    e = '{neg, neg, neg, neg};
    chk_seen("neg", e, 1);

    // mixed top-left window {-7,2,-1,-9}
    for (int i = 0; i < W * H; i++) begin
      int v;
      case (i)
        0: v = -7;
        1: v = 2;
        4: v = -1;
        5: v = -9;
        default: v = -20;
      endcase
      px(v, 1'b0);
    end
    idle(3);
    chk("mixed_count", seen.size(), 4);
    if (seen.size() > 0) chk("mixed_win0", int'(seen[0]), 2);
    seen.delete();
    fd_cnt = 0;

    // frame_start after 6 pixels; pulse for pixel 5 still completes
    for (int i = 0; i < 6; i++) px(i, 1'b0);
    px(0, 1'b1);
    for (int i = 1; i < W * H; i++) px(i, 1'b0);
    idle(3);
    e = '{21'd5, 21'd5, 21'd7, 21'd13, 21'd15};
    chk_seen("fstart", e, 1);

    // async reset after 10 pixels
    for (int i = 0; i < 10; i++) px(i, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    conv_valid = 1'b0;
    q.delete();
    n = 0;
    #1;
    chk("midrst_valid", int'(pool_valid), 0);
    chk("midrst_data", int'(pool_data), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen.delete();
    fd_cnt = 0;
    ramp(0);
    idle(3);
    e = '{21'd5, 21'd7, 21'd13, 21'd15};
    chk_seen("postrst", e, 1);

    // back-to-back frames
    ramp(0);
    ramp(0);
    idle(3);
    e = '{21'd5, 21'd7, 21'd13, 21'd15, 21'd5, 21'd7, 21'd13, 21'd15};
    chk_seen("b2b", e, 2);
    chk("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
